mh_z19_poller: RTL
==================

# mh_z19_poller

Autonomous command sequencer that sits directly upstream of the MH-Z19 CO2 sensor controller and drives its Avalon-MM slave port. It periodically issues the "read gas concentration" command (0x86), reads back the eight captured response bytes, verifies command echo and checksum, and publishes CO2 ppm and raw temperature with a one-cycle valid strobe. It also services on-demand zero-point calibration requests (command 0x87) without host software involvement.

## Interface

Parameters:
- PERIOD_CYCLES, default 50_000_000: clocks between automatic poll launches; must be ≥ 2.
- TW, default $clog2(PERIOD_CYCLES): period timer width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- ena  in  1  enables periodic polling; when low, the timer holds at reload value.
- start  in  1  single-cycle request for an immediate poll; honoured regardless of ena.
- zero_cal_req  in  1  single-cycle request for zero-point calibration.
- m_addr  out  1  controller read address (0: cmd/ppm/byte4, 1: byte5-7/checksum).
- m_wr  out  1  controller write strobe.
- m_wrd  out  32  controller write data {checksum, byte4, byte3, command}.
- m_rdd  in  32  controller read data, combinational from m_addr.
- m_wrq  in  1  controller waitrequest.
- ppm  out  16  last valid CO2 concentration {high, low}.
- temp_raw  out  8  last valid response byte4 (temperature + 40 °C).
- sample_valid  out  1  one-cycle pulse when ppm/temp_raw update.
- err_chk  out  1  one-cycle pulse when a response fails validation.
- cal_done  out  1  one-cycle pulse when a calibration write is accepted.
- busy  out  1  high in every state except IDLE.

## Operation

- Command words: poll m_wrd = 0x7900_0086; calibration m_wrd = 0x7800_0087. m_wrd is registered at launch and held constant until the FSM returns to IDLE.
- Period timer counts down from PERIOD_CYCLES-1 while ena=1 and state=IDLE; poll due at 0. Reloaded on every launch and whenever ena=0.
- start and zero_cal_req each set a sticky pending flag (repeat pulses collapse); cleared on launch of the corresponding command.
- Launch priority in IDLE: cal pending > start pending > timer due.
- States:
  - IDLE: busy=0, m_wr=0; on launch load m_wrd, go WRITE.
  - WRITE: m_wr=1; stay while m_wrq=1. Cycle with m_wrq=0 is acceptance: calibration → IDLE with cal_done pulse; poll → RD0.
  - RD0: m_addr=0; capture m_rdd into word0; go RD1.
  - RD1: m_addr=1; capture m_rdd into word1; go CHECK.
  - CHECK: valid iff word0[7:0]==0x86 and (sum of word0[7:0], word0[15:8], word0[23:16], word0[31:24], word1[7:0], word1[15:8], word1[23:16], word1[31:24]) mod 256 == 0. Sum is 11-bit, compared on low 8 bits. Valid → ppm={word0[15:8],word0[23:16]}, temp_raw=word0[31:24], sample_valid pulse; invalid → err_chk pulse, outputs unchanged. Go IDLE.
- Controller response timeout leaves its registers unchanged; stale data is re-validated as-is (repeat value with sample_valid, or err_chk if never valid).
- start/zero_cal_req arriving while busy are latched and serviced at next IDLE.

## Timing

- Reset values: m_wr=0, m_addr=0, m_wrd=0, ppm=0, temp_raw=0, sample_valid=0, err_chk=0, cal_done=0, busy=0, pending flags 0, timer=PERIOD_CYCLES-1, state IDLE.
- All outputs registered.
- Launch: request sampled in IDLE at edge N → m_wr=1 and m_wrd valid from N+1.
- m_wr drops the cycle after m_wr=1 && m_wrq=0; never asserted two consecutive cycles past acceptance (prevents controller re-trigger).
- Post-acceptance poll: RD0 at +1, RD1 at +2, CHECK at +3, sample_valid/err_chk high for cycle +4, IDLE at +4.
- Timer due and start in same cycle: one poll only; both cleared.
- Reset mid-transaction: immediate return to reset values; the downstream controller is reset by the same net.

## Test plan

- PERIOD_CYCLES=16, ena=1, model returns FF 86 01 9A 40 00 00 00 9F (ppm 410) → m_wrd=0x7900_0086, ppm=0x019A, temp_raw=0x40, one sample_valid per 16-cycle idle period.
- Same, checksum byte 0x9E → err_chk pulse, ppm/temp_raw keep previous values, no sample_valid.
- Model holds m_wrq=1 for 300 cycles → m_wr and m_wrd stable throughout, m_wr low exactly one cycle after m_wrq falls.
- zero_cal_req during a poll → poll completes, then m_wrd=0x7800_0087 write, cal_done pulse, no RD0/RD1.
- ena=0, start pulse → single poll; timer never launches; two start pulses while busy → exactly one extra poll.
- rst low in RD1 → all outputs to reset values next edge; clean poll after release.

Source files
------------

// File: rtl/mh_z19_poller.sv
// mh_z19_poller: periodically sends the MH-Z19 "read gas concentration" command
// to the sensor controller. It reads back the two captured response words,
// validates the command echo and the checksum, and publishes ppm and temperature.
// It also services zero-point calibration requests. All outputs are registered.
module mh_z19_poller #(
    parameter int PERIOD_CYCLES = 50_000_000,
    parameter int TW            = $clog2(PERIOD_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        ena,
    input  logic        start,
    input  logic        zero_cal_req,
    output logic        m_addr,
    output logic        m_wr,
    output logic [31:0] m_wrd,
    input  logic [31:0] m_rdd,
    input  logic        m_wrq,
    output logic [15:0] ppm,
    output logic [7:0]  temp_raw,
    output logic        sample_valid,
    output logic        err_chk,
    output logic        cal_done,
    output logic        busy
);

    // Command words as placed on the controller write port: {checksum, byte4, byte3, command}
    localparam logic [31:0] CMD_POLL = 32'h7900_0086;
    localparam logic [31:0] CMD_CAL  = 32'h7800_0087;
    localparam logic [7:0]  ECHO_CMD = 8'h86;
    localparam logic [TW-1:0] RELOAD = TW'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD0,
        ST_RD1,
        ST_CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_cal_q, pend_cal_d;
    logic          pend_start_q, pend_start_d;
    logic          is_cal_q, is_cal_d;
    logic [31:0]   wrd_q, wrd_d;
    logic [31:0]   word0_q, word0_d;
    logic [31:0]   word1_q, word1_d;
    logic [15:0]   ppm_q, ppm_d;
    logic [7:0]    temp_q, temp_d;
    logic          sv_q, sv_d;
    logic          err_q, err_d;
    logic          cal_done_q, cal_done_d;
    logic          m_wr_q, m_wr_d;
    logic          m_addr_q, m_addr_d;
    logic          busy_q, busy_d;

    logic               timer_due;
    logic               launch_cal;
    logic               launch_poll;
    logic [7:0][7:0]    resp_byte;
    logic [10:0]        chk_sum;
    logic               resp_valid;

    // Byte view of the captured response: bytes 0..3 from word0, 4..7 from word1
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign resp_byte[gi]     = word0_q[gi*8 +: 8];
            assign resp_byte[gi + 4] = word1_q[gi*8 +: 8];
        end
    endgenerate

    // Response check: command echo plus an 8-byte sum that must wrap to zero
    always_comb begin
        chk_sum = '0;
        for (int i = 0; i < 8; i++) begin
            chk_sum = chk_sum + {3'b000, resp_byte[i]};
        end
        resp_valid = (resp_byte[0] == ECHO_CMD) && (chk_sum[7:0] == 8'h00);
    end

    assign timer_due = ena && (timer_q == '0);

    // Launch decision in IDLE: a calibration request outranks a start request, which outranks the timer
    always_comb begin
        launch_cal  = 1'b0;
        launch_poll = 1'b0;
        if (state_q == ST_IDLE) begin
            if (pend_cal_q || zero_cal_req) begin
                launch_cal = 1'b1;
            end else if (pend_start_q || start || timer_due) begin
                launch_poll = 1'b1;
            end
        end
    end

    // Next-state logic for the command sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_cal || launch_poll) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The first cycle without waitrequest is the acceptance cycle
                if (!m_wrq) begin
                    state_d = is_cal_q ? ST_IDLE : ST_RD0;
                end
            end
            ST_RD0:   state_d = ST_RD1;
            ST_RD1:   state_d = ST_CHECK;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: timer, pending flags, command word, capture and result registers
    always_comb begin
        timer_d      = timer_q;
        pend_cal_d   = pend_cal_q | zero_cal_req;
        pend_start_d = pend_start_q | start;
        is_cal_d     = is_cal_q;
        wrd_d        = wrd_q;
        word0_d      = word0_q;
        word1_d      = word1_q;
        ppm_d        = ppm_q;
        temp_d       = temp_q;
        sv_d         = 1'b0;
        err_d        = 1'b0;
        cal_done_d   = 1'b0;

        // The timer only runs while enabled and idle; otherwise it holds or reloads
        if (!ena) begin
            timer_d = RELOAD;
        end else if ((state_q == ST_IDLE) && !launch_cal && !launch_poll) begin
            timer_d = timer_q - TW'(1);
        end

        if (launch_cal) begin
            wrd_d      = CMD_CAL;
            is_cal_d   = 1'b1;
            pend_cal_d = 1'b0;
            timer_d    = RELOAD;
        end else if (launch_poll) begin
            // A timer-due poll and a start request in the same cycle share one poll
            wrd_d        = CMD_POLL;
            is_cal_d     = 1'b0;
            pend_start_d = 1'b0;
            timer_d      = RELOAD;
        end

        case (state_q)
            ST_WRITE: begin
                if (!m_wrq && is_cal_q) begin
                    cal_done_d = 1'b1;
                end
            end
            ST_RD0: word0_d = m_rdd;
            ST_RD1: word1_d = m_rdd;
            ST_CHECK: begin
                if (resp_valid) begin
                    ppm_d  = {resp_byte[1], resp_byte[2]};
                    temp_d = resp_byte[3];
                    sv_d   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered bus controls follow the next state, so they line up with it.
    // m_wr therefore drops right after the acceptance cycle.
    always_comb begin
        m_wr_d   = (state_d == ST_WRITE);
        m_addr_d = (state_d == ST_RD1);
        busy_d   = (state_d != ST_IDLE);
    end

    // State register for the sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q      <= RELOAD;
            pend_cal_q   <= 1'b0;
            pend_start_q <= 1'b0;
            is_cal_q     <= 1'b0;
            wrd_q        <= '0;
            word0_q      <= '0;
            word1_q      <= '0;
            ppm_q        <= '0;
            temp_q       <= '0;
            sv_q         <= 1'b0;
            err_q        <= 1'b0;
            cal_done_q   <= 1'b0;
            m_wr_q       <= 1'b0;
            m_addr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            pend_cal_q   <= pend_cal_d;
            pend_start_q <= pend_start_d;
            is_cal_q     <= is_cal_d;
            wrd_q        <= wrd_d;
            word0_q      <= word0_d;
            word1_q      <= word1_d;
            ppm_q        <= ppm_d;
            temp_q       <= temp_d;
            sv_q         <= sv_d;
            err_q        <= err_d;
            cal_done_q   <= cal_done_d;
            m_wr_q       <= m_wr_d;
            m_addr_q     <= m_addr_d;
            busy_q       <= busy_d;
        end
    end

    assign m_addr       = m_addr_q;
    assign m_wr         = m_wr_q;
    assign m_wrd        = wrd_q;
    assign ppm          = ppm_q;
    assign temp_raw     = temp_q;
    assign sample_valid = sv_q;
    assign err_chk      = err_q;
    assign cal_done     = cal_done_q;
    assign busy         = busy_q;

endmodule
